// File: rtl/perf_mon_pkg.sv
// Shared types and helpers for the pipeline performance monitor.
// Holds the FSM state encoding, the read-select width rule and the saturating increment.
package perf_mon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Widest counter the saturating helper supports; narrower counters zero-extend into it.
   localparam int unsigned MAX_CNT_W = 64;

   // Select width needed to address NUM_EVENTS event counters plus the cycle counter.
   function automatic int unsigned sel_w(input int unsigned num_events);
      return $clog2(num_events + 1);
   endfunction

   function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] val,
                                                   input logic [MAX_CNT_W-1:0] max_val);
      return (val >= max_val) ? max_val : val + MAX_CNT_W'(1);
   endfunction

endpackage

// File: rtl/perf_counter.sv
// One saturating event counter with synchronous clear and a sticky overflow flag.
// The flag sets on the first increment absorbed at full scale.
module perf_counter
   import perf_mon_pkg::*;
#(
   parameter int unsigned CNT_WIDTH = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 clr_i,
   input  logic                 en_i,
   output logic [CNT_WIDTH-1:0] cnt_o,
   output logic                 ovf_o
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 ovf_q, ovf_d;

   always_comb begin
      // NOTE: every always_comb output is defaulted first so no path leaves it unassigned (no latch).
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (en_i) begin
         if (cnt_q == CNT_MAX) ovf_d = 1'b1;
         cnt_d = CNT_WIDTH'(sat_inc(MAX_CNT_W'(cnt_q), MAX_CNT_W'(CNT_MAX)));
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops see pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   assign cnt_o = cnt_q;
   assign ovf_o = ovf_q;

endmodule

// File: rtl/perf_event_monitor.sv
// Pipeline performance monitor: NUM_EVENTS event counters plus a cycle counter over a bounded run.
// Optional shadow snapshot registers are enabled by defining PERF_MON_SNAPSHOT_EN.
module perf_event_monitor
   import perf_mon_pkg::*;
#(
   parameter int unsigned NUM_EVENTS  = 4,
   parameter int unsigned CNT_WIDTH   = 32,
   parameter int unsigned CYCLE_LIMIT = 64
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             start_i,
   input  logic                             clear_i,
   input  logic                             freeze_i,
   input  logic [NUM_EVENTS-1:0]            event_i,
   input  logic                             snapshot_i,
   input  logic                             rd_req_i,
   input  logic [sel_w(NUM_EVENTS)-1:0]     rd_sel_i,
   output logic                             rd_valid_o,
   output logic [CNT_WIDTH-1:0]             rd_data_o,
   output logic [CNT_WIDTH-1:0]             cycle_o,
   output logic                             running_o,
   output logic                             done_o,
   output logic [NUM_EVENTS:0]              overflow_o
);

   localparam int unsigned          SEL_W    = sel_w(NUM_EVENTS);
   localparam bit                   LIMIT_EN = (CYCLE_LIMIT != 0);
   localparam logic [CNT_WIDTH-1:0] LIMIT_M1 = CNT_WIDTH'(LIMIT_EN ? CYCLE_LIMIT - 1 : 0);

   state_e                           state_q;
   logic                             running_q, done_q;
   logic                             count_en, limit_hit;
   logic [NUM_EVENTS:0]              cnt_en;
   logic [NUM_EVENTS:0]              ovf;
   logic [NUM_EVENTS:0][CNT_WIDTH-1:0] cnt_live, rd_src;
   logic [CNT_WIDTH-1:0]             rd_mux;
   logic                             rd_valid_q;
   logic [CNT_WIDTH-1:0]             rd_data_q;

   assign count_en  = (state_q == ST_RUN) && !freeze_i;
   assign limit_hit = LIMIT_EN && (cnt_live[NUM_EVENTS] == LIMIT_M1);

   // Index NUM_EVENTS is the cycle counter; it shares the event counters' saturation logic.
   assign cnt_en[NUM_EVENTS]       = count_en;
   assign cnt_en[NUM_EVENTS-1:0]   = event_i & {NUM_EVENTS{count_en}};

   for (genvar k = 0; k <= NUM_EVENTS; k++) begin : g_cnt
      perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
         .clk_i (clk_i),
         .rst_i (rst_i),
         .clr_i (clear_i),
         .en_i  (cnt_en[k]),
         .cnt_o (cnt_live[k]),
         .ovf_o (ovf[k])
      );
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         state_q   <= ST_IDLE;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: if (start_i) begin
               state_q   <= ST_RUN;
               running_q <= 1'b1;
            end
            ST_RUN: if (count_en && limit_hit) begin
               state_q   <= ST_DONE;
               running_q <= 1'b0;
               done_q    <= 1'b1;
            end
            ST_DONE: ;
            default: begin
               state_q   <= ST_IDLE;
               running_q <= 1'b0;
               done_q    <= 1'b0;
            end
         endcase
      end
   end

`ifdef PERF_MON_SNAPSHOT_EN
   logic [NUM_EVENTS:0][CNT_WIDTH-1:0] shadow_q;

   // NOTE: the shadow bank is a handful of flops with defined reset contents, so it is reset like any register.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) shadow_q <= '0;
      else if (snapshot_i)  shadow_q <= cnt_live;
   end

   assign rd_src = shadow_q;
`else
   logic unused_snapshot;
   assign unused_snapshot = snapshot_i;
   assign rd_src          = cnt_live;
`endif

   always_comb begin
      rd_mux = '0;
      for (int unsigned i = 0; i <= NUM_EVENTS; i++) begin
         if (rd_sel_i == SEL_W'(i)) rd_mux = rd_src[i];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= rd_req_i;
         if (rd_req_i) rd_data_q <= rd_mux;
      end
   end

   assign rd_valid_o = rd_valid_q;
   assign rd_data_o  = rd_data_q;
   assign cycle_o    = cnt_live[NUM_EVENTS];
   assign running_o  = running_q;
   assign done_o     = done_q;
   assign overflow_o = ovf;

endmodule

// File: tb/tb_perf_event_monitor.sv
// Directed bench for perf_event_monitor: three instances (LIMIT=20, 4-bit unlimited, LIMIT=8)
// share one stimulus stream; each step checks the instance it targets.
module tb_perf_event_monitor;

   logic       clk = 1'b0;
   logic       rst, start, clear, freeze, snapshot, rd_req;
   logic [3:0] event_v;
   logic [2:0] rd_sel;

   logic        rd_valid_a, running_a, done_a;
   logic [31:0] rd_data_a, cycle_a;
   logic [4:0]  ovf_a;
   logic        rd_valid_b, running_b, done_b;
   logic [3:0]  rd_data_b, cycle_b;
   logic [4:0]  ovf_b;
   logic        rd_valid_c, running_c, done_c;
   logic [31:0] rd_data_c, cycle_c;
   logic [4:0]  ovf_c;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   perf_event_monitor #(.NUM_EVENTS(4), .CNT_WIDTH(32), .CYCLE_LIMIT(20)) u_a (
      .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .freeze_i(freeze),
      .event_i(event_v), .snapshot_i(snapshot), .rd_req_i(rd_req), .rd_sel_i(rd_sel),
      .rd_valid_o(rd_valid_a), .rd_data_o(rd_data_a), .cycle_o(cycle_a),
      .running_o(running_a), .done_o(done_a), .overflow_o(ovf_a));

   perf_event_monitor #(.NUM_EVENTS(4), .CNT_WIDTH(4), .CYCLE_LIMIT(0)) u_b (
      .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .freeze_i(freeze),
      .event_i(event_v), .snapshot_i(snapshot), .rd_req_i(rd_req), .rd_sel_i(rd_sel),
      .rd_valid_o(rd_valid_b), .rd_data_o(rd_data_b), .cycle_o(cycle_b),
      .running_o(running_b), .done_o(done_b), .overflow_o(ovf_b));

   perf_event_monitor #(.NUM_EVENTS(4), .CNT_WIDTH(32), .CYCLE_LIMIT(8)) u_c (
      .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .freeze_i(freeze),
      .event_i(event_v), .snapshot_i(snapshot), .rd_req_i(rd_req), .rd_sel_i(rd_sel),
      .rd_valid_o(rd_valid_c), .rd_data_o(rd_data_c), .cycle_o(cycle_c),
      .running_o(running_c), .done_o(done_c), .overflow_o(ovf_c));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_cmp++;
      assert (observed === expected) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic do_read(input logic [2:0] sel, input logic snap);
      rd_req   = 1'b1;
      rd_sel   = sel;
      snapshot = snap;
      step();
      rd_req   = 1'b0;
      snapshot = 1'b0;
   endtask

   initial begin
      logic [31:0] exp_snap6;
      rst = 1'b1; start = 1'b0; clear = 1'b0; freeze = 1'b0; snapshot = 1'b0;
      rd_req = 1'b0; rd_sel = '0; event_v = '0;
      step(); step();
      rst = 1'b0;

      // Reset state
      check("rst_running", 32'(running_a), 32'd0);
      check("rst_done",    32'(done_a),    32'd0);
      check("rst_cycle",   cycle_a,        32'd0);
      check("rst_valid",   32'(rd_valid_a), 32'd0);
      check("rst_data",    rd_data_a,      32'd0);
      check("rst_ovf",     32'(ovf_a),     32'd0);

      // 1. Reset mid-RUN, with a read in flight
      start = 1'b1; step(); start = 1'b0;
      event_v = 4'hF;
      for (int i = 0; i < 9; i++) step();
      check("t1_cycle_pre", cycle_a, 32'd9);
      check("t1_run_pre",   32'(running_a), 32'd1);
      rst = 1'b1; rd_req = 1'b1; rd_sel = 3'd0;
      step();
      rst = 1'b0; rd_req = 1'b0; event_v = '0;
      check("t1_running_a", 32'(running_a), 32'd0);
      check("t1_cycle_a",   cycle_a,        32'd0);
      check("t1_valid_a",   32'(rd_valid_a), 32'd0);
      check("t1_data_a",    rd_data_a,      32'd0);
      check("t1_cycle_b",   32'(cycle_b),   32'd0);
      check("t1_running_c", 32'(running_c), 32'd0);
      do_read(3'd0, 1'b0);
      check("t1_rd0_valid", 32'(rd_valid_a), 32'd1);
      check("t1_rd0_data",  rd_data_a,       32'd0);

      // 2. LIMIT=20 run with event 0 on 5 cycles
      start = 1'b1; step(); start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         event_v = (i % 4 == 0) ? 4'b0001 : 4'b0000;
         step();
         if (i == 18) check("t2_done_early", 32'(done_a), 32'd0);
      end
      check("t2_done",    32'(done_a),    32'd1);
      check("t2_running", 32'(running_a), 32'd0);
      check("t2_cycle",   cycle_a,        32'd20);
      check("t2_idle_valid", 32'(rd_valid_a), 32'd0);
      event_v = 4'b0001; start = 1'b1;
      step();
      event_v = '0; start = 1'b0;
      check("t2_hold_done",  32'(done_a), 32'd1);
      check("t2_hold_cycle", cycle_a,     32'd20);
      rd_req = 1'b1; rd_sel = 3'd0; step();
      check("t2_rd0_valid", 32'(rd_valid_a), 32'd1);
      check("t2_rd0_data",  rd_data_a,       32'd5);
      rd_sel = 3'd4; step();
      check("t2_rd4_valid", 32'(rd_valid_a), 32'd1);
      check("t2_rd4_data",  rd_data_a,       32'd20);
      rd_req = 1'b0; step();
      check("t2_noreq_valid", 32'(rd_valid_a), 32'd0);
      check("t2_noreq_hold",  rd_data_a,       32'd20);

      // 3. 4-bit saturation on instance b
      clear = 1'b1; step(); clear = 1'b0;
      check("t3_clr_cycle", 32'(cycle_b), 32'd0);
      start = 1'b1; step(); start = 1'b0;
      event_v = 4'b0010;
      for (int i = 0; i < 20; i++) step();
      event_v = '0;
      check("t3_ovf_bit1", 32'(ovf_b[1]), 32'd1);
      check("t3_ovf_vec",  32'(ovf_b),    32'h12);
      do_read(3'd1, 1'b0);
      check("t3_rd1_data", 32'(rd_data_b), 32'd15);
      clear = 1'b1; step(); clear = 1'b0;
      check("t3_clr_ovf", 32'(ovf_b), 32'd0);
      do_read(3'd1, 1'b0);
      check("t3_clr_rd1", 32'(rd_data_b), 32'd0);

      // 4. Freeze for 3 of 10 RUN cycles
      start = 1'b1; step(); start = 1'b0;
      event_v = 4'hF;
      for (int i = 0; i < 10; i++) begin
         freeze = (i == 2 || i == 5 || i == 7);
         step();
      end
      event_v = '0; freeze = 1'b1;
      for (int s = 0; s <= 4; s++) begin
         do_read(3'(s), 1'b0);
         check($sformatf("t4_rd%0d", s), 32'(rd_data_b), 32'd7);
      end
      freeze = 1'b0;

      // 5. clear+start together, then event on the limit cycle (instance c, LIMIT=8)
      clear = 1'b1; start = 1'b1; step(); clear = 1'b0; start = 1'b0;
      check("t5_idle_run", 32'(running_c), 32'd0);
      check("t5_idle_cyc", cycle_c,        32'd0);
      do_read(3'd0, 1'b0);
      check("t5_zero_rd0", rd_data_c, 32'd0);
      start = 1'b1; step(); start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         event_v = (i == 7) ? 4'b0100 : 4'b0000;
         step();
      end
      event_v = '0;
      check("t5_done",  32'(done_c), 32'd1);
      check("t5_cycle", cycle_c,     32'd8);
      do_read(3'd2, 1'b0);
      check("t5_rd2", rd_data_c, 32'd1);

      // 6. Snapshot at cycle 6, run on to 12 (instance a)
`ifdef PERF_MON_SNAPSHOT_EN
      exp_snap6 = 32'd6;
`else
      exp_snap6 = 32'd12;
`endif
      clear = 1'b1; step(); clear = 1'b0;
      start = 1'b1; step(); start = 1'b0;
      event_v = 4'b1000;
      for (int i = 0; i < 12; i++) begin
         snapshot = (i == 6);
         step();
      end
      snapshot = 1'b0; event_v = '0; freeze = 1'b1;
      check("t6_live_cycle", cycle_a, 32'd12);
      do_read(3'd4, 1'b0);
      check("t6_rd4", rd_data_a, exp_snap6);
      do_read(3'd3, 1'b0);
      check("t6_rd3", rd_data_a, exp_snap6);
      do_read(3'd4, 1'b1);
      check("t6_rd4_coincide", rd_data_a, exp_snap6);
      do_read(3'd4, 1'b0);
      check("t6_rd4_new", rd_data_a, 32'd12);
      do_read(3'd7, 1'b0);
      check("t6_rd7_valid", 32'(rd_valid_a), 32'd1);
      check("t6_rd7_data",  rd_data_a,       32'd0);
      freeze = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
